// File: rtl/soc_system_gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soc_system_gpio_pkg
// Description : Shared constants for the extended GPIO PIO. It holds the
//               Avalon word addresses, the edge-type selector codes and the
//               width helper for the post-reset blanking counter.
// Revision    : 1.0 - initial release
// ============================================================================
package soc_system_gpio_pkg;

    localparam logic [2:0] ADDR_DATA        = 3'd0;
    localparam logic [2:0] ADDR_DIRECTION   = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGECAPTURE = 3'd3;
    localparam logic [2:0] ADDR_OUTSET      = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR    = 3'd5;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // The blanking counter has to hold the values 0..sync_stages+1.
    function automatic int blank_cnt_width(input int sync_stages);
        int w;
        w = $clog2(sync_stages + 2);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : soc_system_gpio_pkg
`default_nettype wire

// File: rtl/soc_system_gpio_sync.sv
`default_nettype none
// ============================================================================
// Module      : soc_system_gpio_sync
// Description : Input path of the GPIO block. It contains the multi-flop
//               synchroniser, a history flop and the per-bit edge detector.
//               Edge outputs are held off until a post-reset blanking count
//               completes, so that pins already asserted at reset do not
//               register as edges.
// Ports       : clk, reset_n     - clock, async active-low reset
//               i_pin  [WIDTH]   - asynchronous pin inputs
//               o_sync [WIDTH]   - synchronised pin value
//               o_edge [WIDTH]   - single-cycle edge-detected strobes
// Revision    : 1.0 - initial release
// ============================================================================
module soc_system_gpio_sync
    import soc_system_gpio_pkg::*;
#(
    parameter int WIDTH       = 24,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_pin,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_edge
);

    localparam int               CNT_W        = blank_cnt_width(SYNC_STAGES);
    localparam logic [CNT_W-1:0] C_BLANK_DONE = CNT_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_hist;
    logic [CNT_W-1:0] r_blank_cnt;
    logic [WIDTH-1:0] w_sync_last;
    logic [WIDTH-1:0] w_raw_edge;
    logic             w_edge_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_hist <= '0;
        end else begin
            r_sync[0] <= i_pin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    // Counts up once after reset release and then parks at the final value.
    // By the time it parks, the history flop has caught up with whatever
    // level the pins held through reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blank_cnt <= '0;
        end else if (r_blank_cnt != C_BLANK_DONE) begin
            r_blank_cnt <= r_blank_cnt + 1'b1;
        end
    end

    assign w_sync_last = r_sync[SYNC_STAGES-1];
    assign w_edge_en   = (r_blank_cnt == C_BLANK_DONE);

    generate
        if (EDGE_TYPE == EDGE_RISING) begin : g_edge_rising
            assign w_raw_edge = w_sync_last & ~r_hist;
        end else if (EDGE_TYPE == EDGE_FALLING) begin : g_edge_falling
            assign w_raw_edge = ~w_sync_last & r_hist;
        end else begin : g_edge_any
            assign w_raw_edge = w_sync_last ^ r_hist;
        end
    endgenerate

    assign o_sync = w_sync_last;
    assign o_edge = w_edge_en ? w_raw_edge : '0;

endmodule : soc_system_gpio_sync
`default_nettype wire

// File: rtl/soc_system_gpio_pio_ext.sv
`default_nettype none
// ============================================================================
// Module      : soc_system_gpio_pio_ext
// Description : Avalon-MM bidirectional GPIO with atomic set/clear, per-bit
//               direction, synchronised inputs, edge capture and a maskable
//               level interrupt.
// Ports       : clk, reset_n                 - clock, async active-low reset
//               address/chipselect/write_n/
//               writedata/readdata           - Avalon-MM slave, 0 wait
//               in_port [WIDTH]              - asynchronous pin inputs
//               out_port [WIDTH]             - output data register
//               oe [WIDTH]                   - per-bit output enable
//               irq                          - active-high level interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module soc_system_gpio_pio_ext
    import soc_system_gpio_pkg::*;
#(
    parameter int               WIDTH       = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = 0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_cap_clr;
    logic [WIDTH-1:0] w_rd;

    assign w_wr    = chipselect & ~write_n;
    assign w_wdata = writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_unused_hi
            logic w_unused_wdata;
            assign w_unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    soc_system_gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_pin   (in_port),
        .o_sync  (w_sync),
        .o_edge  (w_edge)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out  <= RESET_VALUE;
            r_dir  <= '0;
            r_mask <= '0;
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:      r_out  <= w_wdata;
                ADDR_DIRECTION: r_dir  <= w_wdata;
                ADDR_IRQMASK:   r_mask <= w_wdata;
                ADDR_OUTSET:    r_out  <= r_out | w_wdata;
                ADDR_OUTCLEAR:  r_out  <= r_out & ~w_wdata;
                default:        ;
            endcase
        end
    end

    assign w_cap_clr = (w_wr && address == ADDR_EDGECAPTURE) ? w_wdata : '0;

    // The set term is OR-ed in after the clear, so a fresh edge survives a
    // write-1-to-clear aimed at the same bit in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap <= '0;
        end else begin
            r_cap <= (r_cap & ~w_cap_clr) | w_edge;
        end
    end

    always_comb begin
        w_rd = '0;
        case (address)
            ADDR_DATA:        w_rd = (r_out & r_dir) | (w_sync & ~r_dir);
            ADDR_DIRECTION:   w_rd = r_dir;
            ADDR_IRQMASK:     w_rd = r_mask;
            ADDR_EDGECAPTURE: w_rd = r_cap;
            default:          w_rd = '0;
        endcase
    end

    always_comb begin
        readdata             = '0;
        readdata[WIDTH-1:0]  = w_rd;
    end

    assign out_port = r_out;
    assign oe       = r_dir;
    assign irq      = |(r_cap & r_mask);

endmodule : soc_system_gpio_pio_ext
`default_nettype wire

// File: tb/tb_soc_system_gpio_pio_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_soc_system_gpio_pio_ext
// Description : Self-checking bench for the extended GPIO PIO. A reference
//               model keeps the register contents and a history of every
//               pin sample taken since reset; the synchronised value and the
//               edge strobes are looked up from that history by age.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_system_gpio_pio_ext;

    localparam int          W  = 24;
    localparam int          S  = 2;
    localparam int          ET = 0;
    localparam logic [23:0] RV = 24'h00A5A5;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b1;
    logic [2:0]  address    = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = 32'd0;
    logic [31:0] readdata;
    logic [W-1:0] in_port  = '0;
    logic [W-1:0] out_port;
    logic [W-1:0] oe;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    soc_system_gpio_pio_ext #(
        .WIDTH       (W),
        .RESET_VALUE (RV),
        .EDGE_TYPE   (ET),
        .SYNC_STAGES (S)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe         (oe),
        .irq        (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [W-1:0] m_out, m_dir, m_mask, m_cap;
    logic [W-1:0] samp[$];   // pin value sampled at each clock edge since reset

    function automatic logic [W-1:0] sample_at(input int i);
        if (i < 0 || i >= samp.size()) return '0;
        return samp[i];
    endfunction

    // Synchronised pin value = the sample taken S-1 edges before the latest.
    function automatic logic [W-1:0] m_sync();
        return sample_at(samp.size() - S);
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [W-1:0] v;
        case (a)
            3'd0:    v = (m_out & m_dir) | (m_sync() & ~m_dir);
            3'd1:    v = m_dir;
            3'd2:    v = m_mask;
            3'd3:    v = m_cap;
            default: v = '0;
        endcase
        return {8'h00, v};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        int n;
        logic [W-1:0] s, h, e, wd, clr;
        if (!reset_n) begin
            m_out  = RV;
            m_dir  = '0;
            m_mask = '0;
            m_cap  = '0;
            samp.delete();
        end else begin
            n = samp.size();
            s = sample_at(n - S);
            h = sample_at(n - S - 1);
            e = '0;
            // Edges only count once S+1 edges have elapsed since reset release.
            if (n >= S + 1) begin
                case (ET)
                    0:       e = s & ~h;
                    1:       e = ~s & h;
                    default: e = s ^ h;
                endcase
            end
            wd  = writedata[W-1:0];
            clr = '0;
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_out  = wd;
                    3'd1: m_dir  = wd;
                    3'd2: m_mask = wd;
                    3'd3: clr    = wd;
                    3'd4: m_out  = m_out | wd;
                    3'd5: m_out  = m_out & ~wd;
                    default: ;
                endcase
            end
            m_cap = (m_cap & ~clr) | e;
            samp.push_back(in_port);
        end
    end

    // One bus cycle: check outputs against the model, drive new inputs,
    // then check the combinational read for the new address.
    task automatic step(input logic [2:0] a, input logic cs, input logic wn,
                        input logic [31:0] wd, input logic [W-1:0] pin);
        @(negedge clk);
        check("out_port", {8'h00, out_port}, {8'h00, m_out});
        check("oe", {8'h00, oe}, {8'h00, m_dir});
        check("irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        in_port    = pin;
        #1;
        check("readdata", readdata, m_read(a));
    endtask

    logic [W-1:0] pin;

    initial begin
        // Reset with all pins high
        in_port = 24'hFFFFFF;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_out_port", {8'h00, out_port}, 32'h0000A5A5);
        check("rst_oe", {8'h00, oe}, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        repeat (10) step(3'd3, 1'b1, 1'b1, 32'h0, 24'hFFFFFF);
        check("blank_cap", readdata, 32'h0);

        // Direction and mixed DATA read
        step(3'd1, 1'b1, 1'b0, 32'h000000FF, 24'hFFFFFF);
        step(3'd0, 1'b1, 1'b0, 32'h00123456, 24'hABCD00);
        repeat (3) step(3'd0, 1'b1, 1'b1, 32'h0, 24'hABCD00);
        check("data_mix", readdata, 32'h00ABCD56);

        // Atomic set / clear
        step(3'd0, 1'b1, 1'b0, 32'h000F0F0F, 24'h0);
        step(3'd4, 1'b1, 1'b0, 32'h00F00000, 24'h0);
        step(3'd5, 1'b1, 1'b0, 32'h0000000F, 24'h0);
        step(3'd4, 1'b1, 1'b1, 32'h0, 24'h0);
        check("setclr_out", {8'h00, out_port}, 32'h00FF0F00);
        check("rd_outset", readdata, 32'h0);
        step(3'd5, 1'b1, 1'b1, 32'h0, 24'h0);
        check("rd_outclear", readdata, 32'h0);

        // Edge capture latency and interrupt
        step(3'd3, 1'b1, 1'b0, 32'h00FFFFFF, 24'h0);
        step(3'd2, 1'b1, 1'b0, 32'h00000001, 24'h0);
        repeat (3) step(3'd3, 1'b1, 1'b1, 32'h0, 24'h0);
        step(3'd3, 1'b1, 1'b1, 32'h0, 24'h000001);   // sampled at next edge
        step(3'd3, 1'b1, 1'b1, 32'h0, 24'h000001);   // after sampling edge
        step(3'd3, 1'b1, 1'b1, 32'h0, 24'h000001);
        check("irq_early", {31'd0, irq}, 32'h0);
        step(3'd3, 1'b1, 1'b1, 32'h0, 24'h000001);
        check("irq_lat", {31'd0, irq}, 32'h1);
        check("cap_lat", readdata, 32'h00000001);
        step(3'd3, 1'b1, 1'b0, 32'h00000001, 24'h000001);
        step(3'd3, 1'b1, 1'b1, 32'h0, 24'h000001);
        check("irq_clr", {31'd0, irq}, 32'h0);

        // Edge and clear of the same bit in the same cycle
        step(3'd0, 1'b0, 1'b1, 32'h0, 24'h000009);
        step(3'd0, 1'b0, 1'b1, 32'h0, 24'h000009);
        step(3'd3, 1'b1, 1'b0, 32'h00000008, 24'h000009);
        step(3'd3, 1'b1, 1'b1, 32'h0, 24'h000009);
        check("set_wins", {31'd0, readdata[3]}, 32'h1);

        // Randomised traffic with sparse pin toggling
        pin = 24'h000009;
        for (int i = 0; i < 400; i++) begin
            pin = pin ^ W'($urandom & $urandom & $urandom);
            step(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                 $urandom, pin);
        end

        // Mid-operation asynchronous reset
        step(3'd0, 1'b1, 1'b0, 32'h00FFFFFF, 24'h0);
        step(3'd2, 1'b1, 1'b0, 32'h00FFFFFF, 24'h0);
        repeat (4) step(3'd3, 1'b1, 1'b1, 32'h0, 24'h0);
        repeat (4) step(3'd3, 1'b1, 1'b1, 32'h0, 24'hFFFFFF);
        check("pre_rst_irq", {31'd0, irq}, 32'h1);
        check("pre_rst_out", {8'h00, out_port}, 32'h00FFFFFF);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_out", {8'h00, out_port}, 32'h0000A5A5);
        check("mid_rst_oe", {8'h00, oe}, 32'h0);
        check("mid_rst_irq", {31'd0, irq}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) step(3'd3, 1'b1, 1'b1, 32'h0, 24'hFFFFFF);
        check("post_rst_cap", readdata, 32'h0);
        for (int i = 0; i < 100; i++) begin
            pin = W'($urandom);
            step(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                 $urandom, pin);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_soc_system_gpio_pio_ext
`default_nettype wire
